draw_engine: RTL and testbench
==============================

Name: draw_engine

Overview:
- Downstream stage of the edge detector. Services its drawing-engine request/acknowledge handshake.
- Turns pixel-plot and screen-clear commands into byte-masked 32-bit writes to the framebuffer memory port.
- Greyscale 8 bpp, four pixels per word, row-major, linear, base address 0.

Parameters:
SCREEN_W, 640, pixels per line; must be a multiple of 4
SCREEN_H, 480, lines per frame
ADDR_W, 17, framebuffer word-address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H/4

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
de_req  in  1  command request from edge detector (4-phase)
de_ack  out  1  command acknowledge
de_cmd  in  2  command: 00 plot, 01 clear, 10/11 reserved
de_x  in  10  plot x coordinate
de_y  in  9  plot y coordinate
de_colour  in  8  pixel value (plot) or fill value (clear)
busy  out  1  command executing
mem_req  out  1  framebuffer write request
mem_ack  in  1  framebuffer write accepted on this edge
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  write data
mem_be  out  4  byte enables; bit i = byte i = pixel (addr mod 4)==i

Behaviour:
- Reset: de_ack=0, busy=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, FSM=IDLE; handshake state cleared.
- Reset mid-command: the command is abandoned and mem_req is low after the reset edge. No guarantee on partially cleared frames.
- Command handshake, 4-phase:
  - Accept at edge N when de_req=1, de_ack=0 and busy=0. Capture cmd, x, y and colour.
  - de_ack=1 and busy=1 from cycle N+1. de_ack stays high while de_req=1 and falls on the edge after de_req is sampled low.
  - de_x, de_y, de_colour and de_cmd may change once de_ack is seen high.
  - A request pending while busy or while de_ack is still high is held off. It is accepted on the first edge where both are low.
- FSM states: IDLE, PLOT, CLEAR.
- PLOT:
  - lin = y*SCREEN_W + x; mem_addr = lin>>2; mem_be = one-hot(lin[1:0]); mem_wdata = {4{colour}}.
  - mem_req=1 from cycle N+1. Address, data and byte enables are held stable until mem_ack is sampled high.
  - On that edge mem_req falls, busy falls and the FSM returns to IDLE. Minimum busy time is 1 cycle.
- Clipping: x >= SCREEN_W or y >= SCREEN_H gives no memory access. Busy is high for exactly 1 cycle, then IDLE; the command is still acknowledged normally.
- CLEAR:
  - mem_be=4'hF, mem_wdata={4{colour}}, mem_addr starts at 0.
  - mem_req stays high throughout. mem_addr increments on each edge with mem_ack=1.
  - After the ack of the last word (SCREEN_W*SCREEN_H/4 - 1), mem_req and busy fall on that edge.
  - With mem_ack held at 1, CLEAR takes exactly SCREEN_W*SCREEN_H/4 cycles.
- Reserved commands: treated as no-op; acked, 1 busy cycle, no memory access.
- mem_ack while mem_req=0 is ignored.
- Arithmetic: lin is computed at width ADDR_W+2, with no overflow for legal coordinates.

Optional Feature:
- Macro DRAW_ENGINE_CLIP_STATS_EN.
- Defined:
  - Adds output clip_count [15:0], reset to 0.
  - Increments by 1 on each accepted out-of-range plot and saturates at 16'hFFFF.
  - Also adds input clip_clr (1 bit): synchronous clear. clip_clr has priority over a simultaneous increment.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package draw_pkg holds: CMD_PLOT=2'b00, CMD_CLEAR=2'b01, the FSM state encoding, and BPP=8 / PIX_PER_WORD=4.
- One sub-module, fb_addr_gen: combinational (x, y) -> word address, byte enables and in_range flag.
- fb_addr_gen is reused by future read-back paths.

Test Plan:
- Reset, then plot (5,2) colour 8'hA5, mem_ack=1 → de_ack rises cycle after accept. One write: mem_addr=321, mem_be=4'b0010, mem_wdata=32'hA5A5A5A5. busy high for 1 cycle.
- Plot (639,479) colour 8'h3C, with mem_ack delayed 3 cycles → mem_req held 4 cycles with addr=76799 and be=4'b1000 stable. Exactly one write.
- Plot (640,0) → de_ack asserted, no mem_req, busy 1 cycle. With DRAW_ENGINE_CLIP_STATS_EN defined, clip_count goes 0→1.
- Clear colour 8'h00, mem_ack=1 → 76800 consecutive writes, addresses 0..76799, be=4'hF. busy high exactly 76800 cycles.
- Second de_req asserted during a clear → not acked until busy falls. Then accepted and executed; no lost or duplicate command.
- rst_n low for 1 cycle mid-clear at address 100 → all outputs at reset values next cycle. A following plot works normally.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared command codes, FSM encoding and pixel-format constants for the draw engine.
package draw_pkg;

    localparam logic [1:0] CMD_PLOT  = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;

    localparam int BPP          = 8;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLOT  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Replicate one greyscale pixel across every byte lane of a framebuffer word.
    function automatic logic [BPP*PIX_PER_WORD-1:0] fill_word(input logic [BPP-1:0] colour);
        return {PIX_PER_WORD{colour}};
    endfunction

endpackage

// File: rtl/draw_engine_fb_addr_gen.sv
// Combinational pixel (x, y) to framebuffer word address / byte-enable mapping.
// Kept separate so later read-back paths can share the same mapping.
module fb_addr_gen
    import draw_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 17
) (
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        be,
    output logic              in_range
);

    localparam int LIN_W = ADDR_W + 2;

    logic [LIN_W-1:0] lin;

    // Two extra bits hold the byte lane; legal coordinates never overflow LIN_W.
    always_comb begin
        lin      = LIN_W'(y) * LIN_W'(SCREEN_W) + LIN_W'(x);
        addr     = lin[LIN_W-1:2];
        be       = 4'b0001 << lin[1:0];
        in_range = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
    end

endmodule

// File: rtl/draw_engine.sv
// Framebuffer draw engine: 4-phase command handshake, single-pixel plot and full-screen clear.
// Optional clip statistics counter enabled by defining DRAW_ENGINE_CLIP_STATS_EN.
module draw_engine
    import draw_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de_req,
    output logic              de_ack,
    input  logic [1:0]        de_cmd,
    input  logic [9:0]        de_x,
    input  logic [8:0]        de_y,
    input  logic [7:0]        de_colour,
    output logic              busy,
`ifdef DRAW_ENGINE_CLIP_STATS_EN
    input  logic              clip_clr,
    output logic [15:0]       clip_count,
`endif
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H / PIX_PER_WORD - 1);

    state_t            state_q, state_d;
    logic              de_ack_q, de_ack_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [ADDR_W-1:0] gen_addr;
    logic [3:0]        gen_be;
    logic              gen_in_range;
    logic              accept;

    fb_addr_gen #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .x        (de_x),
        .y        (de_y),
        .addr     (gen_addr),
        .be       (gen_be),
        .in_range (gen_in_range)
    );

    // A new request is taken only once the previous handshake and command have both completed.
    assign accept = de_req && !de_ack_q && (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            de_ack_q  <= 1'b0;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            de_ack_q  <= de_ack_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        de_ack_d  = de_ack_q && de_req;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;

        if (accept) begin
            de_ack_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Clipped plots and reserved commands still spend one busy cycle in PLOT, with no write.
                    if (de_cmd == CMD_PLOT) begin
                        state_d   = ST_PLOT;
                        mem_req_d = gen_in_range;
                        addr_d    = gen_addr;
                        be_d      = gen_be;
                        wdata_d   = fill_word(de_colour);
                    end else if (de_cmd == CMD_CLEAR) begin
                        state_d   = ST_CLEAR;
                        mem_req_d = 1'b1;
                        addr_d    = '0;
                        be_d      = 4'hF;
                        wdata_d   = fill_word(de_colour);
                    end else begin
                        state_d   = ST_PLOT;
                        mem_req_d = 1'b0;
                    end
                end
            end

            ST_PLOT: begin
                if (!mem_req_q || mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                if (mem_ack) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign de_ack    = de_ack_q;
    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

`ifdef DRAW_ENGINE_CLIP_STATS_EN
    logic clip_hit;

    assign clip_hit = accept && (de_cmd == CMD_PLOT) && !gen_in_range;

    // Clear wins over a same-cycle clip; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_count <= '0;
        end else if (clip_clr) begin
            clip_count <= '0;
        end else if (clip_hit && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_draw_engine.sv
// Scoreboard bench for draw_engine: directed scenarios plus randomized plots against a pixel-level model.
`timescale 1ns/1ps
module tb_draw_engine;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 17;
    localparam int WORDS    = SCREEN_W * SCREEN_H / 4;

    logic              clk;
    logic              rst_n;
    logic              de_req;
    logic              de_ack;
    logic [1:0]        de_cmd;
    logic [9:0]        de_x;
    logic [8:0]        de_y;
    logic [7:0]        de_colour;
    logic              busy;
    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
`ifdef DRAW_ENGINE_CLIP_STATS_EN
    logic              clip_clr;
    logic [15:0]       clip_count;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       data;
    } wr_t;

    wr_t expQ[$];
    int  busyRuns[$];
    wr_t monHead;
    int  compared   = 0;
    int  mismatched = 0;
    int  expClip    = 0;
    int  lastLatency = 0;
    int  ackMode  = 0;
    int  ackDelay = 0;
    int  ackCnt   = 0;
    int  busyCnt  = 0;

    draw_engine #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .de_req    (de_req),
        .de_ack    (de_ack),
        .de_cmd    (de_cmd),
        .de_x      (de_x),
        .de_y      (de_y),
        .de_colour (de_colour),
        .busy      (busy),
`ifdef DRAW_ENGINE_CLIP_STATS_EN
        .clip_clr  (clip_clr),
        .clip_count(clip_count),
`endif
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, required);
        end
    endtask

    // Memory-side responder: always ready, random, or ready after a fixed wait.
    always @(posedge clk) begin
        #2;
        case (ackMode)
            0: mem_ack = 1'b1;
            1: mem_ack = 1'($urandom_range(0, 1));
            default: begin
                if (mem_req) begin
                    ackCnt++;
                    mem_ack = (ackCnt > ackDelay);
                end else begin
                    ackCnt  = 0;
                    mem_ack = 1'b0;
                end
            end
        endcase
    end

    // Monitor: every presented write must match the queue head; it retires on mem_ack.
    always @(negedge clk) begin
        if (rst_n) begin
            if (expQ.size() == 0) begin
                checkOutput("mem_req_without_command", 64'(mem_req), 64'd0);
            end else if (mem_req) begin
                monHead = expQ[0];
                checkOutput("wr_addr", 64'(mem_addr), 64'(monHead.addr));
                checkOutput("wr_be", 64'(mem_be), 64'(monHead.be));
                checkOutput("wr_data", 64'(mem_wdata), 64'(monHead.data));
                if (mem_ack) void'(expQ.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            busyCnt = 0;
        end else if (busy) begin
            busyCnt++;
        end else if (busyCnt > 0) begin
            busyRuns.push_back(busyCnt);
            busyCnt = 0;
        end
    end

    task automatic modelCommand(input logic [1:0] cmd, input int x, input int y, input logic [7:0] colour);
        wr_t w;
        int  lin;
        if (cmd == 2'b00) begin
            if (x < SCREEN_W && y < SCREEN_H) begin
                lin    = y * SCREEN_W + x;
                w.addr = ADDR_W'(lin / 4);
                w.be   = 4'(1 << (lin % 4));
                w.data = {4{colour}};
                expQ.push_back(w);
            end else if (expClip < 65535) begin
                expClip++;
            end
        end else if (cmd == 2'b01) begin
            for (int a = 0; a < WORDS; a++) begin
                w.addr = ADDR_W'(a);
                w.be   = 4'hF;
                w.data = {4{colour}};
                expQ.push_back(w);
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input int x, input int y, input logic [7:0] colour, input int hold);
        int   waitCycles;
        logic prevBusy;
        bit   got;
        waitCycles = 0;
        got = 0;
        @(posedge clk); #1;
        de_cmd    = cmd;
        de_x      = 10'(x);
        de_y      = 9'(y);
        de_colour = colour;
        de_req    = 1'b1;
        prevBusy  = busy;
        while (waitCycles < 90000) begin
            @(posedge clk); #1;
            waitCycles++;
            if (de_ack) begin
                got = 1;
                break;
            end
            prevBusy = busy;
        end
        lastLatency = waitCycles;
        checkOutput("ack_received", 64'(got), 64'd1);
        if (got) begin
            checkOutput("accept_while_busy", 64'(prevBusy), 64'd0);
            modelCommand(cmd, x, y, colour);
            de_x      = 10'($urandom);
            de_y      = 9'($urandom);
            de_colour = 8'($urandom);
            de_cmd    = 2'($urandom);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checkOutput("ack_held", 64'(de_ack), 64'd1);
            end
            de_req = 1'b0;
            @(posedge clk); #1;
            checkOutput("ack_fall", 64'(de_ack), 64'd0);
        end
        de_req = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 0;
        for (int i = 0; i < 90000; i++) begin
            @(posedge clk); #3;
            if (!busy && expQ.size() == 0) begin
                done = 1;
                break;
            end
        end
        checkOutput("idle_reached", 64'(done), 64'd1);
        @(negedge clk); #1;
    endtask

    task automatic checkBusyRun(input string name, input int required);
        int got;
        got = (busyRuns.size() > 0) ? busyRuns.pop_front() : -1;
        checkOutput(name, 64'(got), 64'(required));
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_de_ack", 64'(de_ack), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("rst_mem_be", 64'(mem_be), 64'd0);
`ifdef DRAW_ENGINE_CLIP_STATS_EN
        checkOutput("rst_clip_count", 64'(clip_count), 64'd0);
`endif
    endtask

    task automatic checkClip();
`ifdef DRAW_ENGINE_CLIP_STATS_EN
        checkOutput("clip_count", 64'(clip_count), 64'(expClip));
`endif
    endtask

    initial begin
        bit   hit;
        int   r;
        int   x;
        int   y;
        logic [1:0] cmd;

        rst_n     = 1'b0;
        de_req    = 1'b0;
        de_cmd    = 2'b00;
        de_x      = '0;
        de_y      = '0;
        de_colour = '0;
        mem_ack   = 1'b0;
`ifdef DRAW_ENGINE_CLIP_STATS_EN
        clip_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        rst_n = 1'b1;

        $display("[TB] plot (5,2), memory always ready");
        ackMode = 0;
        busyRuns.delete();
        applyStimulus(2'b00, 5, 2, 8'hA5, 0);
        checkOutput("plot_ack_latency", 64'(lastLatency), 64'd1);
        waitIdle();
        checkBusyRun("plot_busy_cycles", 1);

        $display("[TB] plot (639,479), memory waits 3 cycles");
        ackMode  = 2;
        ackDelay = 3;
        applyStimulus(2'b00, 639, 479, 8'h3C, 1);
        waitIdle();
        checkBusyRun("slow_plot_busy_cycles", 4);

        $display("[TB] clipped plot and reserved commands");
        ackMode = 0;
        applyStimulus(2'b00, 640, 0, 8'h12, 0);
        waitIdle();
        checkBusyRun("clip_busy_cycles", 1);
        checkClip();
        applyStimulus(2'b10, 3, 3, 8'h55, 0);
        applyStimulus(2'b11, 4, 4, 8'h66, 2);
        waitIdle();
        checkBusyRun("reserved10_busy_cycles", 1);
        checkBusyRun("reserved11_busy_cycles", 1);

        $display("[TB] full clear with a request queued behind it");
        busyRuns.delete();
        applyStimulus(2'b01, 0, 0, 8'h00, 0);
        applyStimulus(2'b00, 100, 50, 8'h77, 0);
        waitIdle();
        checkBusyRun("clear_busy_cycles", WORDS);
        checkBusyRun("queued_plot_busy_cycles", 1);
        checkOutput("busy_runs_left", 64'(busyRuns.size()), 64'd0);

        $display("[TB] reset in the middle of a clear");
        applyStimulus(2'b01, 0, 0, 8'h5A, 0);
        hit = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (mem_addr == ADDR_W'(100)) begin
                hit = 1;
                break;
            end
        end
        checkOutput("clear_reached_100", 64'(hit), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkResetOutputs();
        expQ.delete();
        expClip = 0;
        rst_n = 1'b1;
        busyRuns.delete();
        applyStimulus(2'b00, 7, 3, 8'h11, 0);
        checkOutput("post_reset_ack_latency", 64'(lastLatency), 64'd1);
        waitIdle();
        checkBusyRun("post_reset_busy_cycles", 1);

`ifdef DRAW_ENGINE_CLIP_STATS_EN
        $display("[TB] clip counter clear");
        applyStimulus(2'b00, 700, 10, 8'h01, 0);
        applyStimulus(2'b00, 10, 480, 8'h02, 0);
        waitIdle();
        checkClip();
        @(posedge clk); #1;
        clip_clr = 1'b1;
        @(posedge clk); #1;
        clip_clr = 1'b0;
        expClip = 0;
        checkClip();
`endif

        $display("[TB] randomized commands, random memory backpressure");
        ackMode = 1;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                cmd = 2'b00;
                x = $urandom_range(0, SCREEN_W - 1);
                y = $urandom_range(0, SCREEN_H - 1);
            end else if (r < 85) begin
                cmd = 2'b00;
                x = $urandom_range(0, 1023);
                y = $urandom_range(SCREEN_H, 511);
            end else begin
                cmd = 2'($urandom_range(2, 3));
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 511);
            end
            applyStimulus(cmd, x, y, 8'($urandom), $urandom_range(0, 2));
        end
        waitIdle();
        checkClip();
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
